// File: rtl/sfp_pkg.sv
// sfp_pkg: shared FSM states, saturation bounds and column slicing for sfp_accum_array.
package sfp_pkg;

    typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_t;

    function automatic logic signed [63:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

    function automatic int col_lsb(input int c, input int bw);
        return c * bw;
    endfunction

endpackage

// File: rtl/sfp_lane.sv
// sfp_lane: single-column accumulate / write-through / ReLU datapath.
// SFP_SAT_EN: saturate WS accumulate on overflow instead of wrapping.
module sfp_lane import sfp_pkg::*; #(
    parameter int W = 16
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] din,
    input  logic         os,
    input  logic         first,
    input  logic         relu,
    input  logic [W-1:0] raw,
    output logic [W-1:0] nxt,
    output logic         ovf,
    output logic [W-1:0] dout
);

    logic [W:0]   sum;
    logic         ov;
    logic         ws_acc;
    logic [W-1:0] acc_res;

    assign sum    = {acc[W-1], acc} + {din[W-1], din};
    assign ov     = sum[W] ^ sum[W-1];
    assign ws_acc = !os && !first;
    assign ovf    = ws_acc && ov;

`ifdef SFP_SAT_EN
    localparam logic [W-1:0] SMAX = W'(sat_max(W));
    localparam logic [W-1:0] SMIN = W'(sat_min(W));
    assign acc_res = ov ? (sum[W] ? SMIN : SMAX) : sum[W-1:0];
`else
    assign acc_res = sum[W-1:0];
`endif

    assign nxt  = ws_acc ? acc_res : din;
    assign dout = (relu && raw[W-1]) ? '0 : raw;

endmodule

// File: rtl/sfp_accum_array.sv
// sfp_accum_array: multi-column accumulator array with WS/OS input and ReLU drain stream.
// SFP_SAT_EN (in sfp_lane): saturating WS accumulate.
module sfp_accum_array import sfp_pkg::*; #(
    parameter  int COL     = 8,
    parameter  int PSUM_BW = 16,
    parameter  int DEPTH   = 16,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   mode,
    input  logic                   relu_en,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PSUM_BW*COL-1:0] in_data,
    input  logic [AW-1:0]          in_addr,
    input  logic                   in_first,
    input  logic                   drain_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PSUM_BW*COL-1:0] out_data,
    output logic [AW-1:0]          out_addr,
    output logic                   busy,
    output logic                   done,
    output logic                   ovf
);

    state_t                 state_q, state_d;
    logic [PSUM_BW*COL-1:0] mem [DEPTH];
    logic [PSUM_BW*COL-1:0] wr_acc, wr_nxt, rd_raw, drain_word;
    logic [COL-1:0]         lane_ovf;
    logic [AW-1:0]          rd;
    logic                   relu_q;
    logic                   last;

    // While a beat is on the bus the next entry is prefetched so handshakes stream without bubbles.
    assign rd       = out_valid ? out_addr + 1'b1 : out_addr;
    assign wr_acc   = mem[in_addr];
    assign rd_raw   = mem[rd];
    assign last     = out_addr == AW'(DEPTH - 1);
    assign in_ready = state_q == IDLE;
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;

    for (genvar c = 0; c < COL; c++) begin : g_lane
        sfp_lane #(.W(PSUM_BW)) u_lane (
            .acc  (wr_acc[col_lsb(c, PSUM_BW) +: PSUM_BW]),
            .din  (in_data[col_lsb(c, PSUM_BW) +: PSUM_BW]),
            .os   (mode),
            .first(in_first),
            .relu (relu_q),
            .raw  (rd_raw[col_lsb(c, PSUM_BW) +: PSUM_BW]),
            .nxt  (wr_nxt[col_lsb(c, PSUM_BW) +: PSUM_BW]),
            .ovf  (lane_ovf[c]),
            .dout (drain_word[col_lsb(c, PSUM_BW) +: PSUM_BW])
        );
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    state_d = drain_start ? DRAIN : IDLE;
            DRAIN:   state_d = (out_valid && out_ready && last) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            relu_q    <= 1'b0;
            ovf       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE) begin
                if (in_valid) mem[in_addr] <= wr_nxt;
                if (drain_start) begin
                    relu_q   <= relu_en;
                    out_addr <= '0;
                end
                ovf <= (ovf && !drain_start) || (in_valid && |lane_ovf);
            end else if (state_q == DRAIN) begin
                if (!out_valid) begin
                    out_valid <= 1'b1;
                    out_data  <= drain_word;
                end else if (out_ready) begin
                    mem[out_addr] <= '0;
                    out_valid     <= !last;
                    out_data      <= drain_word;
                    out_addr      <= out_addr + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sfp_accum_array.sv
// tb_sfp_accum_array: directed stimulus with a cycle-level behavioural model checked every cycle.
module tb_sfp_accum_array;

    localparam int COL   = 8;
    localparam int W     = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int MAXV  = (1 << (W - 1)) - 1;
    localparam int MINV  = -(1 << (W - 1));

    logic clk = 0, reset = 1, mode = 0, relu_en = 0, in_valid = 0, in_first = 0;
    logic drain_start = 0, out_ready = 1;
    logic in_ready, out_valid, busy, done, ovf;
    logic [W*COL-1:0] in_data = '0, out_data;
    logic [AW-1:0]    in_addr = '0, out_addr;

    int tests = 0, fails = 0;
    int mm [DEPTH][COL];
    int m_phase = 0, m_ptr = 0, dones = 0, beats = 0;
    logic m_ovf = 0, m_relu = 0;
    logic [W*COL-1:0] got [DEPTH];

    sfp_accum_array #(.COL(COL), .PSUM_BW(W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .mode(mode), .relu_en(relu_en),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_addr(in_addr), .in_first(in_first), .drain_start(drain_start),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_addr(out_addr), .busy(busy), .done(done), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [W*COL-1:0] exp_word(input int a);
        logic [W*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[c*W +: W] = W'((m_relu && mm[a][c] < 0) ? 0 : mm[a][c]);
        return r;
    endfunction

    function automatic logic [W*COL-1:0] colv(input int base);
        logic [W*COL-1:0] r;
        for (int c = 0; c < COL; c++) r[c*W +: W] = W'(base + c);
        return r;
    endfunction

    // Model: phase 0 idle, 1 first drain cycle, 2 streaming, 3 done pulse.
    always @(negedge clk) begin
        if (reset) begin
            for (int a = 0; a < DEPTH; a++)
                for (int c = 0; c < COL; c++) mm[a][c] = 0;
            m_phase = 0; m_ptr = 0; m_ovf = 0; m_relu = 0;
        end else begin
            chk("in_ready", in_ready, m_phase == 0);
            chk("busy", busy, m_phase != 0);
            chk("done", done, m_phase == 3);
            chk("ovf", ovf, m_ovf);
            chk("out_valid", out_valid, m_phase == 2);
            if (m_phase == 2) begin
                chk("out_addr", out_addr, m_ptr);
                chk("out_data", out_data, exp_word(m_ptr));
            end
            case (m_phase)
                0: begin
                    if (drain_start) begin
                        m_ovf = 0; m_relu = relu_en; m_ptr = 0; m_phase = 1;
                    end
                    if (in_valid)
                        for (int c = 0; c < COL; c++) begin
                            int d, s;
                            d = $signed(in_data[c*W +: W]);
                            if (mode || in_first) s = d;
                            else begin
                                s = mm[in_addr][c] + d;
                                if (s > MAXV || s < MINV) begin
                                    m_ovf = 1;
`ifdef SFP_SAT_EN
                                    s = (s > MAXV) ? MAXV : MINV;
`else
                                    s = (s > MAXV) ? s - (1 << W) : s + (1 << W);
`endif
                                end
                            end
                            mm[in_addr][c] = s;
                        end
                end
                1: m_phase = 2;
                2: if (out_ready) begin
                    got[m_ptr] = out_data;
                    for (int c = 0; c < COL; c++) mm[m_ptr][c] = 0;
                    beats++;
                    if (m_ptr == DEPTH - 1) m_phase = 3;
                    else m_ptr++;
                end
                default: begin
                    m_phase = 0;
                    dones++;
                end
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic m, input logic f, input int a, input logic [W*COL-1:0] d);
        mode = m; in_first = f; in_addr = AW'(a); in_data = d; in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic drain(input logic r, input logic stall, input logic junk);
        int d0, b0, k;
        logic [3:0] pat;
        pat = 4'b1001;
        d0 = dones; b0 = beats;
        relu_en = r; drain_start = 1;
        tick();
        drain_start = 0; relu_en = 0;
        if (junk) begin
            in_valid = 1; mode = 1; in_addr = 5; in_data = {COL{16'd99}};
        end
        k = 0;
        while (dones == d0 && k < 200) begin
            out_ready = stall ? pat[k % 4] : 1'b1;
            tick();
            k++;
        end
        in_valid = 0; out_ready = 1;
        chk("drain_done_count", dones - d0, 1);
        chk("drain_beats", beats - b0, DEPTH);
    endtask

    initial begin
        int k;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_ovf", ovf, 0);
        tick();

        beat(0, 1, 3, {COL{16'd5}});
        beat(0, 0, 3, {COL{16'd7}});
        beat(0, 0, 3, {COL{16'hFFFE}});
        drain(0, 0, 0);
        chk("ws_addr3", got[3], {COL{16'd10}});
        chk("ws_addr0", got[0], 0);

        beat(1, 0, 1, colv(100));
        beat(1, 0, 1, colv(40));
        drain(0, 0, 0);
        chk("os_addr1_col0", got[1][W-1:0], 16'd40);
        chk("os_addr1_col7", got[1][W*COL-1 -: W], 16'd47);

        beat(0, 1, 0, {COL{16'h7FF0}});
        beat(0, 0, 0, {COL{16'h0020}});
        chk("ovf_set", ovf, 1);
        drain(0, 0, 0);
`ifdef SFP_SAT_EN
        chk("ovf_value", got[0], {COL{16'h7FFF}});
`else
        chk("ovf_value", got[0], {COL{16'h8010}});
`endif
        chk("ovf_clr", ovf, 0);

        beat(0, 1, 2, {COL{16'hFFF7}});
        beat(0, 1, 4, {COL{16'd6}});
        drain(1, 0, 0);
        chk("relu_neg", got[2], 0);
        chk("relu_pos", got[4], {COL{16'd6}});

        drain(0, 1, 1);
        for (int a = 0; a < DEPTH; a++) chk("zero_drain", got[a], 0);

        mode = 0; in_first = 1; in_addr = 0; in_data = {COL{16'd11}};
        in_valid = 1; drain_start = 1;
        tick();
        in_valid = 0; drain_start = 0; in_first = 0;
        k = 0;
        while (!(m_phase == 2 && m_ptr == 5) && k < 100) begin
            tick();
            k++;
        end
        chk("reach_ptr5", m_ptr, 5);
        chk("beat_in_drain", got[0], {COL{16'd11}});
        reset = 1;
        tick();
        reset = 0;
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        tick();
        drain(0, 0, 0);
        chk("post_rst_addr0", got[0], 0);
        chk("post_rst_addr15", got[15], 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sfp_accum_array.md
Name: sfp_accum_array

Overview:
Multi-column special-function post-processor sitting after the OFIFO in the corelet, replacing the per-column single-register sfp instances.
- Holds DEPTH accumulator entries per column, addressed by output index.
- Supports weight-stationary accumulate mode and output-stationary write-through mode.
- Drains results with optional ReLU over a valid/ready stream.

Parameters:
COL, 8, number of parallel columns (channels)
PSUM_BW, 16, signed partial-sum width per column
DEPTH, 16, accumulator entries per column (power of two, >=2)
AW, $clog2(DEPTH), entry address width (derived, not overridden)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
mode  in  1  0 = WS accumulate, 1 = OS write-through; sampled per input beat
relu_en  in  1  apply ReLU on drain; sampled at drain_start
in_valid  in  1  input beat valid
in_ready  out  1  block can accept an input beat
in_data  in  PSUM_BW*COL  column psums, column c at [PSUM_BW*(c+1)-1 : PSUM_BW*c]
in_addr  in  AW  target entry
in_first  in  1  first beat for this entry: overwrite instead of accumulate
drain_start  in  1  request drain of all entries
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts output beat
out_data  out  PSUM_BW*COL  drained entry, same column packing
out_addr  out  AW  index of the drained entry
busy  out  1  high in DRAIN and DONE
done  out  1  one-cycle pulse after last drain beat accepted
ovf  out  1  sticky overflow flag; cleared by reset or drain_start

Behaviour:
- Storage: DEPTH x COL signed PSUM_BW registers, all cleared to 0 on reset.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_data=0, out_addr=0, done=0, busy=0, ovf=0, drain pointer 0.
- States: IDLE, DRAIN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, entry in_addr is updated at the next edge, per column:
    - WS and !in_first: acc + in (signed add).
    - WS and in_first: in.
    - OS: in, regardless of in_first.
  - Back-to-back beats to the same address accumulate correctly with no bubbles, since the write is visible on the next cycle.
- drain_start in IDLE:
  - Go to DRAIN. Pointer=0. Latch relu_en. Clear ovf.
  - An in_valid beat in the same cycle is accepted and included in the drain.
- drain_start outside IDLE is ignored.
- DRAIN:
  - in_ready=0; input beats are not accepted.
  - Output registered: out_valid rises the cycle after entering DRAIN, with out_data=f(acc[0]) and out_addr=0.
  - f = ReLU (negative -> 0) if the latched relu_en is set, else identity.
  - While out_valid && !out_ready, out_data and out_addr are held stable.
  - On handshake:
    - Clear the drained entry to 0.
    - Pointer+1; present the next entry the following cycle with no bubble (out_valid stays high).
  - After the handshake of entry DEPTH-1: out_valid=0, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Reset mid-drain: immediate return to reset values; all entries cleared.
- Arithmetic: sum computed at PSUM_BW+1 bits; overflow = the two MSBs differ; overflow sets ovf.
- Address wrap: none; in_addr is always in range by width.

Optional Feature:
SFP_SAT_EN
- Defined: on overflow the WS accumulate saturates to +2^(PSUM_BW-1)-1 or -2^(PSUM_BW-1); ovf is set.
- Undefined: two's-complement wrap modulo 2^PSUM_BW; ovf is still set on overflow.
- OS write-through never overflows in either case.

Decomposition:
- Package sfp_pkg:
  - State enum (IDLE, DRAIN, DONE).
  - Saturation min/max constants as functions of PSUM_BW.
  - Column slice helper function.
- One natural sub-module: sfp_lane (single-column add / saturate / ReLU datapath, combinational), instantiated COL times via generate.
- Storage and FSM stay in the top.

Test Plan:
- Reset, then WS beats to addr 3 of +5 (first), +7, -2 on all columns; drain with relu_en=0 and out_ready=1 -> addr 3 reads 10, other entries 0; DEPTH consecutive beats; done pulses once.
- OS mode, addr 1 beats 100 then 40 -> drained addr 1 = 40.
- WS addr 0: 0x7FF0 (first) + 0x0020 -> 0x7FFF and ovf=1 with SFP_SAT_EN; 0x8010 and ovf=1 without.
- relu_en=1 with addr 2 = -9 and addr 4 = 6 -> drain shows 0 and 6; a second drain afterwards reads all zeros.
- out_ready toggled 1,0,0,1 during drain -> data and addr held across stalls; no entry skipped or duplicated; in_ready=0 throughout.
- in_valid together with drain_start, then reset asserted at pointer 5 -> the beat is included in out_data; after reset out_valid=0 and busy=0, and a following drain returns all zeros.
